// File: rtl/pll_ctrl_pkg.sv
// Shared types and constants for the PLL lock sequencer: FSM states,
// the phase-shift setup time and the sizing helper for the shared counter.
package pll_ctrl_pkg;

    typedef enum logic [2:0] {
        RST,
        WAIT,
        STAB,
        RUN,
        PSU,
        PSH,
        PSL
    } state_t;

    localparam int PS_SETUP = 2;

    // The shared counter must reach LOCK_TIMEOUT-1; every other limit is smaller.
    function automatic int cnt_width(input int timeout);
        return (timeout > 2) ? $clog2(timeout) : 1;
    endfunction

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for the asynchronous PLL LOCK input, cleared to 0 on reset.
module sync_2ff (
    input  logic clk,
    input  logic resetn,
    input  logic d,
    output logic q
);

    logic meta;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            meta <= 1'b0;
            q    <= 1'b0;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/pll_lock_sequencer.sv
// Sequences PLL reset, lock qualification and downstream reset release,
// and serves valid/ready phase-shift requests once the PLL is stable.
module pll_lock_sequencer
    import pll_ctrl_pkg::*;
#(
    parameter int RST_CYCLES   = 64,
    parameter int LOCK_TIMEOUT = 65536,
    parameter int LOCK_STABLE  = 1024,
    parameter int PS_PULSE_W   = 4,
    parameter int PS_GAP       = 8
) (
    input  logic       clk,
    input  logic       resetn,
    input  logic       pll_lock,
    output logic       pll_reset,
    output logic       sys_resetn,
    output logic       ready,
    input  logic       ps_valid,
    output logic       ps_ready,
    input  logic [2:0] ps_sel,
    input  logic       ps_dir,
    input  logic [3:0] ps_steps,
    output logic       ps_done,
    output logic       ps_err,
    output logic [2:0] pssel,
    output logic       psdir,
    output logic       pspulse,
    output logic       lock_err,
    output logic [7:0] relock_cnt
);

    localparam int CW = cnt_width(LOCK_TIMEOUT);

    state_t        state, state_nx;
    logic [CW-1:0] cnt, cnt_nx;
    logic [3:0]    steps_left, steps_nx;
    logic          lock_s;
    logic          take, lock_loss, timeout, done_ok, done_abort;
    logic          pll_reset_nx, ready_nx, ps_ready_nx, pspulse_nx;
    logic          ps_done_nx, ps_err_nx, psdir_nx, lock_err_nx;
    logic [2:0]    pssel_nx;
    logic [7:0]    relock_nx;

    sync_2ff u_lock_sync (
        .clk    (clk),
        .resetn (resetn),
        .d      (pll_lock),
        .q      (lock_s)
    );

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state      <= RST;
            cnt        <= '0;
            steps_left <= '0;
            pll_reset  <= 1'b1;
            sys_resetn <= 1'b0;
            ready      <= 1'b0;
            ps_ready   <= 1'b0;
            pspulse    <= 1'b0;
            pssel      <= '0;
            psdir      <= 1'b0;
            ps_done    <= 1'b0;
            ps_err     <= 1'b0;
            lock_err   <= 1'b0;
            relock_cnt <= '0;
        end else begin
            state      <= state_nx;
            cnt        <= cnt_nx;
            steps_left <= steps_nx;
            pll_reset  <= pll_reset_nx;
            sys_resetn <= ready_nx;
            ready      <= ready_nx;
            ps_ready   <= ps_ready_nx;
            pspulse    <= pspulse_nx;
            pssel      <= pssel_nx;
            psdir      <= psdir_nx;
            ps_done    <= ps_done_nx;
            ps_err     <= ps_err_nx;
            lock_err   <= lock_err_nx;
            relock_cnt <= relock_nx;
        end
    end

    // The WAIT cycle that first sees lock counts as the first stable sample.
    always_comb begin
        state_nx   = state;
        cnt_nx     = cnt + CW'(1);
        steps_nx   = steps_left;
        take       = 1'b0;
        timeout    = 1'b0;
        done_ok    = 1'b0;
        lock_loss  = !lock_s && (state inside {RUN, PSU, PSH, PSL});
        done_abort = 1'b0;
        case (state)
            RST: begin
                if (cnt == CW'(RST_CYCLES - 1)) begin
                    state_nx = WAIT;
                    cnt_nx   = '0;
                end
            end
            WAIT: begin
                if (lock_s) begin
                    state_nx = STAB;
                    cnt_nx   = CW'(1);
                end else if (cnt == CW'(LOCK_TIMEOUT - 1)) begin
                    state_nx = RST;
                    cnt_nx   = '0;
                    timeout  = 1'b1;
                end
            end
            STAB: begin
                if (!lock_s) begin
                    state_nx = WAIT;
                    cnt_nx   = '0;
                end else if (cnt == CW'(LOCK_STABLE - 1)) begin
                    state_nx = RUN;
                    cnt_nx   = '0;
                end
            end
            RUN: begin
                cnt_nx = '0;
                if (!lock_s) begin
                    state_nx   = RST;
                    done_abort = ps_valid && ps_ready;
                end else if (ps_valid && ps_ready) begin
                    take     = 1'b1;
                    steps_nx = ps_steps;
                    if (ps_steps == 4'd0) begin
                        done_ok = 1'b1;
                    end else begin
                        state_nx = PSU;
                    end
                end
            end
            PSU, PSH, PSL: begin
                if (!lock_s) begin
                    state_nx   = RST;
                    cnt_nx     = '0;
                    done_abort = 1'b1;
                end else if (state == PSU && cnt == CW'(PS_SETUP - 1)) begin
                    state_nx = PSH;
                    cnt_nx   = '0;
                end else if (state == PSH && cnt == CW'(PS_PULSE_W - 1)) begin
                    state_nx = PSL;
                    cnt_nx   = '0;
                    steps_nx = steps_left - 4'd1;
                end else if (state == PSL && cnt == CW'(PS_GAP - 1)) begin
                    cnt_nx = '0;
                    if (steps_left != 4'd0) begin
                        state_nx = PSH;
                    end else begin
                        state_nx = RUN;
                        done_ok  = 1'b1;
                    end
                end
            end
            default: begin
                state_nx = RST;
                cnt_nx   = '0;
            end
        endcase
    end

    // Outputs are computed from the next state so they register in step with it.
    always_comb begin
        pll_reset_nx = (state_nx == RST);
        ready_nx     = (state_nx inside {RUN, PSU, PSH, PSL});
        ps_ready_nx  = (state_nx == RUN);
        pspulse_nx   = (state_nx == PSH);
        pssel_nx     = take ? ps_sel : pssel;
        psdir_nx     = take ? ps_dir : psdir;
        ps_done_nx   = done_ok || done_abort;
        ps_err_nx    = done_abort;
        lock_err_nx  = lock_err || timeout;
        relock_nx    = (lock_loss && relock_cnt != 8'hFF) ? relock_cnt + 8'd1 : relock_cnt;
    end

endmodule

// File: tb/tb_pll_lock_sequencer.sv
// Directed bench for pll_lock_sequencer with small parameters; cycle t is
// the period after the t-th rising edge following reset release.
module tb_pll_lock_sequencer;

    localparam int RST_CYCLES   = 8;
    localparam int LOCK_TIMEOUT = 64;
    localparam int LOCK_STABLE  = 16;
    localparam int PS_PULSE_W   = 2;
    localparam int PS_GAP       = 3;

    logic       clk      = 1'b0;
    logic       resetn   = 1'b0;
    logic       pll_lock = 1'b0;
    logic       ps_valid = 1'b0;
    logic [2:0] ps_sel   = '0;
    logic       ps_dir   = 1'b0;
    logic [3:0] ps_steps = '0;
    logic       pll_reset, sys_resetn, ready, ps_ready, ps_done, ps_err;
    logic       psdir, pspulse, lock_err;
    logic [2:0] pssel;
    logic [7:0] relock_cnt;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    pll_lock_sequencer #(
        .RST_CYCLES   (RST_CYCLES),
        .LOCK_TIMEOUT (LOCK_TIMEOUT),
        .LOCK_STABLE  (LOCK_STABLE),
        .PS_PULSE_W   (PS_PULSE_W),
        .PS_GAP       (PS_GAP)
    ) dut (
        .clk        (clk),
        .resetn     (resetn),
        .pll_lock   (pll_lock),
        .pll_reset  (pll_reset),
        .sys_resetn (sys_resetn),
        .ready      (ready),
        .ps_valid   (ps_valid),
        .ps_ready   (ps_ready),
        .ps_sel     (ps_sel),
        .ps_dir     (ps_dir),
        .ps_steps   (ps_steps),
        .ps_done    (ps_done),
        .ps_err     (ps_err),
        .pssel      (pssel),
        .psdir      (psdir),
        .pspulse    (pspulse),
        .lock_err   (lock_err),
        .relock_cnt (relock_cnt)
    );

    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0d expected %0d", tag, actual, expected);
        end
    endtask

    task automatic checkResetValues(input string tag);
        checkOutput({tag, " pll_reset"},  pll_reset,  1);
        checkOutput({tag, " sys_resetn"}, sys_resetn, 0);
        checkOutput({tag, " ready"},      ready,      0);
        checkOutput({tag, " ps_ready"},   ps_ready,   0);
        checkOutput({tag, " pspulse"},    pspulse,    0);
        checkOutput({tag, " pssel"},      pssel,      0);
        checkOutput({tag, " psdir"},      psdir,      0);
        checkOutput({tag, " ps_done"},    ps_done,    0);
        checkOutput({tag, " ps_err"},     ps_err,     0);
        checkOutput({tag, " lock_err"},   lock_err,   0);
        checkOutput({tag, " relock_cnt"}, relock_cnt, 0);
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    // Presents a request at a negedge; the handshake completes on the next rising edge.
    task automatic applyStimulus(input logic [2:0] sel, input logic dir, input logic [3:0] steps);
        ps_valid = 1'b1;
        ps_sel   = sel;
        ps_dir   = dir;
        ps_steps = steps;
        tick();
        ps_valid = 1'b0;
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        $display("[TB] power-up sequence");
        repeat (5) tick();
        checkResetValues("por");
        resetn = 1'b1;
        for (int t = 0; t <= 40; t++) begin
            checkOutput($sformatf("pu pll_reset t=%0d", t),  pll_reset,  t <= 7);
            checkOutput($sformatf("pu ready t=%0d", t),      ready,      t >= 38);
            checkOutput($sformatf("pu sys_resetn t=%0d", t), sys_resetn, t >= 38);
            if (t == 20) pll_lock = 1'b1;
            tick();
        end

        $display("[TB] phase shift, 3 steps");
        checkOutput("ps3 ps_ready before", ps_ready, 1);
        applyStimulus(3'd2, 1'b1, 4'd3);
        for (int k = 0; k <= 18; k++) begin
            checkOutput($sformatf("ps3 pspulse k=%0d", k), pspulse,
                        k == 2 || k == 3 || k == 7 || k == 8 || k == 12 || k == 13);
            checkOutput($sformatf("ps3 ps_done k=%0d", k),  ps_done,  k == 17);
            checkOutput($sformatf("ps3 ps_err k=%0d", k),   ps_err,   0);
            checkOutput($sformatf("ps3 ps_ready k=%0d", k), ps_ready, k >= 17);
            if (k <= 16) begin
                checkOutput($sformatf("ps3 pssel k=%0d", k), pssel, 2);
                checkOutput($sformatf("ps3 psdir k=%0d", k), psdir, 1);
            end
            tick();
        end

        $display("[TB] phase shift, 0 steps");
        applyStimulus(3'd4, 1'b0, 4'd0);
        for (int k = 0; k <= 3; k++) begin
            checkOutput($sformatf("ps0 ps_done k=%0d", k),  ps_done,  k == 0);
            checkOutput($sformatf("ps0 ps_err k=%0d", k),   ps_err,   0);
            checkOutput($sformatf("ps0 pspulse k=%0d", k),  pspulse,  0);
            checkOutput($sformatf("ps0 ps_ready k=%0d", k), ps_ready, 1);
            tick();
        end

        $display("[TB] lock loss while pspulse is high");
        applyStimulus(3'd1, 1'b0, 4'd2);
        pll_lock = 1'b0;
        for (int k = 0; k <= 34; k++) begin
            checkOutput($sformatf("ll pspulse k=%0d", k),    pspulse,    k == 2);
            checkOutput($sformatf("ll ps_done k=%0d", k),    ps_done,    k == 3);
            checkOutput($sformatf("ll ps_err k=%0d", k),     ps_err,     k == 3);
            checkOutput($sformatf("ll ready k=%0d", k),      ready,      k <= 2 || k >= 33);
            checkOutput($sformatf("ll sys_resetn k=%0d", k), sys_resetn, k <= 2 || k >= 33);
            checkOutput($sformatf("ll pll_reset k=%0d", k),  pll_reset,  k >= 3 && k <= 10);
            checkOutput($sformatf("ll relock_cnt k=%0d", k), relock_cnt, (k >= 3) ? 1 : 0);
            if (k == 15) pll_lock = 1'b1;
            tick();
        end

        $display("[TB] lock loss in RUN, then a one-cycle glitch during STAB");
        pll_lock = 1'b0;
        for (int k = 0; k <= 43; k++) begin
            checkOutput($sformatf("gl ready k=%0d", k),      ready,      k <= 2 || k >= 42);
            checkOutput($sformatf("gl relock_cnt k=%0d", k), relock_cnt, (k >= 3) ? 2 : 1);
            if (k == 13 || k == 24) pll_lock = 1'b1;
            if (k == 23) pll_lock = 1'b0;
            tick();
        end

        $display("[TB] asynchronous reset during PSL");
        applyStimulus(3'd5, 1'b1, 4'd1);
        repeat (5) tick();
        checkOutput("arst pspulse before", pspulse, 0);
        checkOutput("arst pssel before",   pssel,   5);
        checkOutput("arst psdir before",   psdir,   1);
        checkOutput("arst ready before",   ready,   1);
        #2 resetn = 1'b0;
        #1 checkResetValues("arst");

        $display("[TB] lock timeout with pll_lock held low");
        pll_lock = 1'b0;
        repeat (3) tick();
        resetn = 1'b1;
        for (int t = 0; t <= 152; t++) begin
            checkOutput($sformatf("to lock_err t=%0d", t), lock_err, t >= 72);
            checkOutput($sformatf("to pll_reset t=%0d", t), pll_reset,
                        t <= 7 || (t >= 72 && t <= 79) || (t >= 144 && t <= 151));
            checkOutput($sformatf("to ready t=%0d", t), ready, 0);
            tick();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
